// File: rtl/umem_pkg.sv
// Shared types and constants for the unified memory controller.
package umem_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    CH_I,
    CH_D
  } chan_t;

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Instruction read channel and data read/write channel between requesters
// (master) and the unified memory controller (slave).
interface unified_mem_ctrl_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  i_ready, i_rdata,
    input  d_ready, d_rdata
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output i_ready, i_rdata,
    output d_ready, d_rdata
  );

endinterface

// File: rtl/umem_array.sv
// Byte-enabled word storage: combinational read, synchronous byte-masked write.
// Each byte lane is its own array so lane writes never share a driver.
module umem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory controller with a fixed wait-state FSM.
// Define UMEM_ROUND_ROBIN_EN to alternate contested grants; otherwise data wins.
module unified_mem_ctrl
  import umem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  unified_mem_ctrl_if.slave  bus,
  output logic               busy
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  chan_t              grant_reg, grant_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               we_reg, we_next;
  logic [3:0]         be_reg, be_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [31:0]        i_rdata_reg;
  logic [31:0]        d_rdata_reg;
  chan_t              win;
  logic               mem_we;
  logic [31:0]        mem_rdata;
  logic               i_ready_int;
  logic               d_ready_int;

  // Only the word-index slice of each address matters; the rest wraps away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:IDX_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:IDX_W+2], bus.d_addr[1:0]};

`ifdef UMEM_ROUND_ROBIN_EN
  chan_t rr_ptr_reg, rr_ptr_next;

  always_comb begin
    if (bus.i_req && bus.d_req) begin
      win = rr_ptr_reg;
    end else if (bus.d_req) begin
      win = CH_D;
    end else begin
      win = CH_I;
    end
  end

  // Pointer moves only on contested grants; lone requests leave it alone.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (state_reg == ST_IDLE && bus.i_req && bus.d_req) begin
      rr_ptr_next = (rr_ptr_reg == CH_I) ? CH_D : CH_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= CH_I;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  always_comb begin
    win = bus.d_req ? CH_D : CH_I;
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    we_next    = we_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant_next = win;
          if (win == CH_D) begin
            idx_next = bus.d_addr[IDX_W+1:2];
            we_next  = bus.d_we;
          end else begin
            idx_next = bus.i_addr[IDX_W+1:2];
            we_next  = 1'b0;
          end
          be_next    = bus.d_be;
          wdata_next = bus.d_wdata;
          cnt_next   = CNT_W'(WAIT);
          state_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      grant_reg   <= CH_I;
      idx_reg     <= '0;
      we_reg      <= 1'b0;
      be_reg      <= 4'b0000;
      wdata_reg   <= 32'h0;
      i_rdata_reg <= 32'h0;
      d_rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      we_reg    <= we_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      // Capture read data so rdata holds until that channel's next read.
      if (state_reg == ST_RESP && !we_reg) begin
        if (grant_reg == CH_I) begin
          i_rdata_reg <= mem_rdata;
        end else begin
          d_rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign i_ready_int = (state_reg == ST_RESP) && (grant_reg == CH_I);
  assign d_ready_int = (state_reg == ST_RESP) && (grant_reg == CH_D);
  assign mem_we      = d_ready_int && we_reg;

  umem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be_reg),
    .addr  (idx_reg),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  assign bus.i_ready = i_ready_int;
  assign bus.d_ready = d_ready_int;
  assign bus.i_rdata = i_ready_int ? mem_rdata : i_rdata_reg;
  assign bus.d_rdata = (d_ready_int && !we_reg) ? mem_rdata : d_rdata_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Self-checking bench for unified_mem_ctrl (DEPTH=256/WAIT=2, plus a WAIT=0 instance).
module tb_unified_mem_ctrl;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic busy0;

  unified_mem_ctrl_if bus ();
  unified_mem_ctrl_if bus0 ();

  unified_mem_ctrl #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  unified_mem_ctrl #(.DEPTH(16), .WAIT(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0),
    .busy  (busy0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [DEPTH];
`ifdef UMEM_ROUND_ROBIN_EN
  bit rr_next_d = 1'b0;
`endif

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT=2 instance; ch=1 selects the data channel. Called at a negedge.
  task automatic access(input bit ch, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int          lat;
    bit          done;
    bit          other_seen;
    logic [31:0] got;
    logic [31:0] d_before;
    logic [31:0] exp;
    d_before = bus.d_rdata;
    if (ch) begin
      bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end
    lat = 0; done = 1'b0; other_seen = 1'b0; got = '0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ch ? bus.i_ready : bus.d_ready) other_seen = 1'b1;
      if (ch ? bus.d_ready : bus.i_ready) begin
        done = 1'b1;
        got  = ch ? bus.d_rdata : bus.i_rdata;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
    chk({tag, "_other_ready"}, 32'(other_seen), 32'd0);
    if (ch && we) begin
      ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], wdata, be);
      exp = d_before;
    end else begin
      exp = ref_mem[widx(addr)];
    end
    chk({tag, "_rdata"}, got, exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {29'd0, bus.i_ready, bus.d_ready, busy}, 32'd0);
    chk({tag, "_hold"}, ch ? bus.d_rdata : bus.i_rdata, exp);
    $display("[TB] %s ch=%s we=%0d be=%b addr=%h wdata=%h rdata=%h lat=%0d",
             tag, ch ? "D" : "I", we, be, addr, wdata, got, lat);
  endtask

  // Both channels read in the same cycle; checks who wins and that both complete.
  task automatic contest(input string tag);
    logic [31:0] ia;
    logic [31:0] da;
    bit          exp_first;
    bit          first;
    bit          both_seen;
    int          got_n;
    int          cyc;
    ia = $urandom; da = $urandom;
`ifdef UMEM_ROUND_ROBIN_EN
    exp_first = rr_next_d;
    rr_next_d = ~rr_next_d;
`else
    exp_first = 1'b1;
`endif
    bus.i_addr = ia; bus.d_addr = da; bus.d_we = 1'b0; bus.d_be = 4'hF;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    got_n = 0; cyc = 0; first = 1'b0; both_seen = 1'b0;
    while (got_n < 2 && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.i_ready && bus.d_ready) both_seen = 1'b1;
      if (bus.i_ready) begin
        if (got_n == 0) first = 1'b0;
        chk({tag, "_i_rdata"}, bus.i_rdata, ref_mem[widx(ia)]);
        bus.i_req = 1'b0;
        got_n++;
      end
      if (bus.d_ready) begin
        if (got_n == 0) first = 1'b1;
        chk({tag, "_d_rdata"}, bus.d_rdata, ref_mem[widx(da)]);
        bus.d_req = 1'b0;
        got_n++;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, "_both_done"}, 32'(got_n), 32'd2);
    chk({tag, "_first_winner"}, 32'(first), 32'(exp_first));
    chk({tag, "_exclusive"}, 32'(both_seen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    $display("[TB] %s first=%s cycles=%0d", tag, first ? "D" : "I", cyc);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          ch;
    bit          we;
    int          e0;
    int          e1;
    int          hits;
    logic [31:0] g0;

    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus0.i_req = 0; bus0.i_addr = '0;
    bus0.d_req = 0; bus0.d_we = 0; bus0.d_be = '0; bus0.d_addr = '0; bus0.d_wdata = '0;

    // Reset state
    #2;
    chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Fill every word so reads never touch undefined storage
    for (int w = 0; w < DEPTH; w++) access(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom, "init");

    // Full-word write then instruction read
    access(1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, "w_full");
    access(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, "i_read40");
    chk("i_read40_value", bus.i_rdata, 32'hDEADBEEF);

    // Byte-enable merge and empty-mask write
    access(1'b1, 1'b1, 4'b0001, 32'h40, 32'h000000AA, "w_be1");
    access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, "d_read40");
    chk("be1_value", bus.d_rdata, 32'hDEADBEAA);
    access(1'b1, 1'b1, 4'b0000, 32'h40, 32'h55555555, "w_be0");
    access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, "d_read40b");
    chk("be0_value", bus.d_rdata, 32'hDEADBEAA);

    // Address wrap beyond DEPTH words
    access(1'b1, 1'b1, 4'hF, 32'h400, 32'h12345678, "w_wrap");
    access(1'b0, 1'b0, 4'h0, 32'h000, 32'h0, "r_wrap");
    chk("wrap_value", bus.i_rdata, 32'h12345678);

    // Randomized traffic against the reference array
    for (int k = 0; k < 24; k++) begin
      ch = 1'($urandom_range(0, 1));
      we = ch ? 1'($urandom_range(0, 1)) : 1'b0;
      access(ch, we, 4'($urandom), $urandom, $urandom, "rnd");
    end

    // Contested grants
    for (int k = 0; k < 4; k++) contest("contest");

    // Reset in the middle of a write
    access(1'b1, 1'b1, 4'hF, 32'h10, 32'h0, "pre_rst_w");
    access(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, "pre_rst_i");
    access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, "pre_rst_d");
    bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h10; bus.d_wdata = 32'hFFFFFFFF;
    bus.d_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_i_ready", 32'(bus.i_ready), 32'd0);
    chk("abort_d_ready", 32'(bus.d_ready), 32'd0);
    chk("abort_i_rdata", bus.i_rdata, 32'd0);
    chk("abort_d_rdata", bus.d_rdata, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    bus.d_req = 1'b0;
`ifdef UMEM_ROUND_ROBIN_EN
    rr_next_d = 1'b0;
`endif
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "post_abort_read");
    chk("abort_no_write", bus.i_rdata, 32'h00000000);
    contest("contest_after_rst");

    // WAIT=0 instance: single-cycle latency and 2-cycle spacing
    bus0.d_we = 1'b1; bus0.d_be = 4'hF; bus0.d_addr = 32'h8; bus0.d_wdata = 32'hCAFEF00D;
    bus0.d_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!bus0.d_ready && n < 10);
    bus0.d_req = 1'b0;
    chk("w0_lat", 32'(n), 32'd1);
    $display("[TB] wait0 write lat=%0d", n);
    @(posedge clk);
    @(negedge clk);
    bus0.i_addr = 32'h8; bus0.i_req = 1'b1;
    e0 = -1; e1 = -1; hits = 0; g0 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus0.i_ready) begin
        if (hits == 0) begin e0 = c; g0 = bus0.i_rdata; end
        if (hits == 1) e1 = c;
        hits++;
      end
    end
    bus0.i_req = 1'b0;
    chk("w0_read_lat", 32'(e0), 32'd1);
    chk("w0_spacing", 32'(e1 - e0), 32'd2);
    chk("w0_hits", 32'(hits), 32'd3);
    chk("w0_rdata", g0, 32'hCAFEF00D);
    $display("[TB] wait0 reads first=%0d second=%0d count=%0d rdata=%h", e0, e1, hits, g0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
